// File: rtl/bus_mux_reg.sv
// Internal-bus source mux: fixed-priority select of G, D or a general register,
// with optional output register, hold-last-value mode and contention tracking.
module bus_mux_reg #(
  parameter int WIDTH     = 9,
  parameter int NREG      = 8,
  parameter int REG_OUT   = 1,
  parameter int HOLD_LAST = 1,
  parameter int CNT_W     = 8,
  localparam int SRC_W    = $clog2(NREG + 3)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREG*WIDTH-1:0] in_r,
  input  logic [WIDTH-1:0]      in_d,
  input  logic [WIDTH-1:0]      in_g,
  input  logic [NREG-1:0]       rsel,
  input  logic                  dsel,
  input  logic                  gsel,
  input  logic                  en,
  input  logic                  clr_err,
  output logic [WIDTH-1:0]      bus_out,
  output logic [SRC_W-1:0]      bus_src,
  output logic                  bus_vld,
  output logic                  conflict,
  output logic                  err_sticky,
  output logic [CNT_W-1:0]      err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             sel_any;
  logic [WIDTH-1:0] win_val;
  logic [SRC_W-1:0] win_src;
  logic [SRC_W-1:0] sel_pop;

  logic [WIDTH-1:0] last_q, last_d;
  logic             err_sticky_q, err_sticky_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Registers are scanned high to low so the lowest set index ends up winning;
  // D and G are applied last so they override any register.
  always_comb begin
    win_val = '0;
    win_src = '0;
    sel_pop = '0;
    sel_any = gsel | dsel | (|rsel);
    for (int i = NREG - 1; i >= 0; i--) begin
      if (rsel[i]) begin
        win_val = in_r[i*WIDTH +: WIDTH];
        win_src = SRC_W'(i + 3);
      end
      sel_pop = sel_pop + SRC_W'(rsel[i]);
    end
    if (dsel) begin
      win_val = in_d;
      win_src = SRC_W'(2);
    end
    if (gsel) begin
      win_val = in_g;
      win_src = SRC_W'(1);
    end
    sel_pop = sel_pop + SRC_W'(gsel) + SRC_W'(dsel);
    if (!sel_any && (HOLD_LAST != 0)) begin
      win_val = last_q;
    end
  end

  assign conflict = (sel_pop >= SRC_W'(2));

  always_comb begin
    last_d       = last_q;
    err_sticky_d = err_sticky_q;
    err_cnt_d    = err_cnt_q;
    if (en && sel_any) begin
      last_d = win_val;
    end
    if (clr_err) begin
      err_sticky_d = 1'b0;
      err_cnt_d    = '0;
    end else if (conflict) begin
      err_sticky_d = 1'b1;
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q       <= '0;
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      last_q       <= last_d;
      err_sticky_q <= err_sticky_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign err_sticky = err_sticky_q;
  assign err_cnt    = err_cnt_q;

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] out_q, out_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic             vld_q, vld_d;

    always_comb begin
      out_d = out_q;
      src_d = src_q;
      vld_d = vld_q;
      if (en) begin
        out_d = win_val;
        src_d = win_src;
        vld_d = sel_any;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        out_q <= '0;
        src_q <= '0;
        vld_q <= 1'b0;
      end else begin
        out_q <= out_d;
        src_q <= src_d;
        vld_q <= vld_d;
      end
    end

    assign bus_out = out_q;
    assign bus_src = src_q;
    assign bus_vld = vld_q;
  end else begin : g_comb_out
    assign bus_out = win_val;
    assign bus_src = win_src;
    assign bus_vld = sel_any;
  end

endmodule
